// File: rtl/lsu_data_ram_if.sv
// lsu_data_ram_if: request/ready/done bus between the datapath and lsu_data_ram.
interface lsu_data_ram_if;
   logic        iReq;
   logic        iWe;
   logic [2:0]  iFunct3;
   logic [31:0] iAddr;
   logic [31:0] iWrData;
   logic        oReady;
   logic        oDone;
   logic [31:0] oRdData;
   logic        oMisalign;

   modport master (
      output iReq, iWe, iFunct3, iAddr, iWrData,
      input  oReady, oDone, oRdData, oMisalign
   );

   modport slave (
      input  iReq, iWe, iFunct3, iAddr, iWrData,
      output oReady, oDone, oRdData, oMisalign
   );
endinterface

// File: rtl/lsu_data_ram.sv
// lsu_data_ram: RV32I load/store unit with a DEPTH x 32 byte-strobed data RAM.
// Optional macro MISALIGN_SPLIT_EN: misaligned accesses are performed (split over
// two RAM words when they cross a word) instead of being rejected with oMisalign.
module lsu_data_ram #(
   parameter int unsigned DEPTH = 256
) (
   input logic           iClk,
   input logic           iRst,
   lsu_data_ram_if.slave bus
);
   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned AQ_W   = ADDR_W + 2;
`ifdef MISALIGN_SPLIT_EN
   localparam bit SPLIT_EN = 1'b1;
`else
   localparam bit SPLIT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, ACC, ACC2, RESP} state_t;

   state_t            state;
   logic              we_q;
   logic [2:0]        f3_q;
   logic [AQ_W-1:0]   addr_q;
   logic [31:0]       wd_q;
   logic [31:0]       rd_q;
   logic [31:0]       rd0_q;

   // Zero at time 0; never touched by reset.
   logic [31:0]       mem [DEPTH] = '{default: '0};

   logic [1:0]        ofs_c;
   logic [ADDR_W-1:0] idx0_c;
   logic              legal_c;
   logic              is_h_c;
   logic              is_w_c;
   logic [3:0]        base_be_c;
   logic              mis_c;
   logic              split_c;
   logic              ok_c;
   logic [7:0]        be64_c;
   logic [63:0]       wd64_c;
   logic              ram_we_c;
   logic [ADDR_W-1:0] ram_idx_c;
   logic [3:0]        ram_be_c;
   logic [31:0]       ram_wd_c;
   logic [63:0]       word64_c;
   logic [31:0]       lane_c;
   logic [31:0]       fmt_c;
   logic              unused_addr_hi;

   assign ofs_c          = addr_q[1:0];
   assign idx0_c         = addr_q[AQ_W-1:2];
   assign unused_addr_hi = ^bus.iAddr[31:AQ_W];

   // Decode the captured request: size, legality, misalignment and word split.
   always_comb begin
      legal_c   = 1'b0;
      is_h_c    = 1'b0;
      is_w_c    = 1'b0;
      base_be_c = 4'b0000;
      case (f3_q)
         3'b000, 3'b100: begin legal_c = 1'b1; base_be_c = 4'b0001; end
         3'b001, 3'b101: begin legal_c = 1'b1; is_h_c = 1'b1; base_be_c = 4'b0011; end
         3'b010:         begin legal_c = 1'b1; is_w_c = 1'b1; base_be_c = 4'b1111; end
         default: ;
      endcase
      mis_c   = (is_h_c && ofs_c[0]) || (is_w_c && (ofs_c != 2'b00));
      split_c = SPLIT_EN && ((is_h_c && (ofs_c == 2'b11)) || (is_w_c && (ofs_c != 2'b00)));
      ok_c    = legal_c && (SPLIT_EN || !mis_c);
      be64_c  = {4'b0000, base_be_c} << ofs_c;
      wd64_c  = {32'h0, wd_q} << {ofs_c, 3'b000};
   end

   // RAM port control: word0 in ACC, word0+1 (wrapping) in ACC2.
   always_comb begin
      ram_we_c  = 1'b0;
      ram_idx_c = idx0_c;
      ram_be_c  = be64_c[3:0];
      ram_wd_c  = wd64_c[31:0];
      case (state)
         ACC:  ram_we_c = we_q && ok_c;
         ACC2: begin
            ram_we_c  = we_q && ok_c;
            ram_idx_c = idx0_c + ADDR_W'(1);
            ram_be_c  = be64_c[7:4];
            ram_wd_c  = wd64_c[63:32];
         end
         default: ;
      endcase
   end

   // Single synchronous RAM port with byte strobes, read-before-write.
   always_ff @(posedge iClk) begin
      for (int b = 0; b < 4; b++) begin
         if (ram_we_c && ram_be_c[b]) begin
            mem[ram_idx_c][8*b +: 8] <= ram_wd_c[8*b +: 8];
         end
      end
      rd_q <= mem[ram_idx_c];
   end

   // Align the (possibly two-word) read data and sign/zero-extend it.
   always_comb begin
      word64_c = split_c ? {rd_q, rd0_q} : {32'h0, rd_q};
      lane_c   = 32'(word64_c >> {ofs_c, 3'b000});
      fmt_c    = 32'h0;
      if (!we_q && ok_c) begin
         case (f3_q)
            3'b000:  fmt_c = {{24{lane_c[7]}}, lane_c[7:0]};
            3'b001:  fmt_c = {{16{lane_c[15]}}, lane_c[15:0]};
            3'b010:  fmt_c = lane_c;
            3'b100:  fmt_c = {24'h0, lane_c[7:0]};
            3'b101:  fmt_c = {16'h0, lane_c[15:0]};
            default: fmt_c = 32'h0;
         endcase
      end
   end

   // Control FSM with request capture and registered handshake/response outputs.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state         <= IDLE;
         we_q          <= 1'b0;
         f3_q          <= 3'b000;
         addr_q        <= '0;
         wd_q          <= 32'h0;
         rd0_q         <= 32'h0;
         bus.oReady    <= 1'b1;
         bus.oDone     <= 1'b0;
         bus.oRdData   <= 32'h0;
         bus.oMisalign <= 1'b0;
      end else begin
         bus.oDone <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.iReq) begin
                  we_q       <= bus.iWe;
                  f3_q       <= bus.iFunct3;
                  addr_q     <= bus.iAddr[AQ_W-1:0];
                  wd_q       <= bus.iWrData;
                  bus.oReady <= 1'b0;
                  state      <= ACC;
               end
            end
            ACC:  state <= split_c ? ACC2 : RESP;
            ACC2: begin
               rd0_q <= rd_q;
               state <= RESP;
            end
            RESP: begin
               bus.oRdData   <= fmt_c;
               bus.oMisalign <= mis_c && !SPLIT_EN;
               bus.oDone     <= 1'b1;
               bus.oReady    <= 1'b1;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lsu_data_ram.sv
// tb_lsu_data_ram: directed stimulus with a queue-based scoreboard for lsu_data_ram.
module tb_lsu_data_ram;
   localparam int unsigned DEPTH = 256;
   localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

   typedef struct {
      logic [31:0] rd;
      logic        mis;
      int          lat;
      int          issue;
   } exp_t;

   logic  iClk = 1'b0;
   logic  iRst;
   int    cyc = 0;
   int    checks = 0;
   int    failures = 0;
   exp_t  sb[$];
   string sb_name[$];
   logic [31:0] w10;

   lsu_data_ram_if bus();

   lsu_data_ram #(.DEPTH(DEPTH)) dut (
      .iClk (iClk),
      .iRst (iRst),
      .bus  (bus.slave)
   );

   always #5 iClk = ~iClk;
   always @(posedge iClk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   // Pops one expected response per oDone and compares data, flag, latency, ready.
   task automatic monitor();
      exp_t  e;
      string n;
      forever begin
         @(negedge iClk);
         if (iRst === 1'b0 && bus.oDone === 1'b1) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 32'(bus.oDone), 32'd0);
            end else begin
               e = sb.pop_front();
               n = sb_name.pop_front();
               check({n, "_rd"},    bus.oRdData, e.rd);
               check({n, "_mis"},   32'(bus.oMisalign), 32'(e.mis));
               check({n, "_lat"},   32'(cyc - e.issue), 32'(e.lat));
               check({n, "_ready"}, 32'(bus.oReady), 32'd1);
            end
         end
      end
   endtask

   // Called at a negedge; waits for oReady, drives one request cycle, queues expectation.
   task automatic issue(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input logic mis, input int lat);
      exp_t e;
      int   n = 0;
      while (bus.oReady !== 1'b1 && n < 20) begin
         @(negedge iClk);
         n++;
      end
      if (bus.oReady !== 1'b1) check({name, "_ready_timeout"}, 32'(bus.oReady), 32'd1);
      bus.iReq    = 1'b1;
      bus.iWe     = we;
      bus.iFunct3 = f3;
      bus.iAddr   = addr;
      bus.iWrData = wd;
      e.rd    = rd;
      e.mis   = mis;
      e.lat   = lat;
      e.issue = cyc;
      sb.push_back(e);
      sb_name.push_back(name);
      @(negedge iClk);
      bus.iReq    = 1'b0;
      bus.iWe     = ~we;
      bus.iFunct3 = 3'b111;
      bus.iAddr   = ~addr;
      bus.iWrData = ~wd;
   endtask

   task automatic st(input string name, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input logic mis, input int lat);
      issue(name, 1'b1, f3, addr, wd, 32'h0, mis, lat);
   endtask

   task automatic ld(input string name, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] rd, input logic mis, input int lat);
      issue(name, 1'b0, f3, addr, 32'h0, rd, mis, lat);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge iClk);
         n++;
      end
      if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      iRst        = 1'b1;
      bus.iReq    = 1'b0;
      bus.iWe     = 1'b0;
      bus.iFunct3 = 3'b000;
      bus.iAddr   = 32'h0;
      bus.iWrData = 32'h0;
      fork
         monitor();
      join_none
      repeat (2) @(negedge iClk);
      check("rst_ready", 32'(bus.oReady), 32'd1);
      check("rst_done",  32'(bus.oDone), 32'd0);
      check("rst_rd",    bus.oRdData, 32'h0);
      check("rst_mis",   32'(bus.oMisalign), 32'd0);
      iRst = 1'b0;
      @(negedge iClk);

      // Word store/load, byte and halfword lanes with sign/zero extension.
      st("sw_10",  F_W,  32'h10, 32'hDEADBEEF, 1'b0, 3);
      ld("lw_10",  F_W,  32'h10, 32'hDEADBEEF, 1'b0, 3);
      st("sb_11",  F_B,  32'h11, 32'h000000AA, 1'b0, 3);
      ld("lw_10b", F_W,  32'h10, 32'hDEADAAEF, 1'b0, 3);
      ld("lb_11",  F_B,  32'h11, 32'hFFFFFFAA, 1'b0, 3);
      ld("lbu_11", F_BU, 32'h11, 32'h000000AA, 1'b0, 3);
      st("sh_22",  F_H,  32'h22, 32'h00008001, 1'b0, 3);
      ld("lh_22",  F_H,  32'h22, 32'hFFFF8001, 1'b0, 3);
      ld("lhu_22", F_HU, 32'h22, 32'h00008001, 1'b0, 3);
      ld("lw_20",  F_W,  32'h20, 32'h80010000, 1'b0, 3);
      ld("lb_23",  F_B,  32'h23, 32'hFFFFFF80, 1'b0, 3);
      ld("lbu_22", F_BU, 32'h22, 32'h00000001, 1'b0, 3);

      // Illegal funct3: no write, zero data, no misalign.
      st("ill_st3", 3'b011, 32'h20, 32'hFFFFFFFF, 1'b0, 3);
      st("ill_st7", 3'b111, 32'h20, 32'hFFFFFFFF, 1'b0, 3);
      ld("ill_ld6", 3'b110, 32'h20, 32'h0, 1'b0, 3);
      ld("lw_20b",  F_W,    32'h20, 32'h80010000, 1'b0, 3);

`ifdef MISALIGN_SPLIT_EN
      st("sw_10c",  F_W,  32'h10,  32'h44332211, 1'b0, 3);
      st("sw_14",   F_W,  32'h14,  32'h88776655, 1'b0, 3);
      ld("lw_13",   F_W,  32'h13,  32'h77665544, 1'b0, 4);
      ld("lh_11",   F_H,  32'h11,  32'h00003322, 1'b0, 3);
      ld("lh_13",   F_H,  32'h13,  32'h00005544, 1'b0, 4);
      ld("lh_16",   F_H,  32'h16,  32'hFFFF8877, 1'b0, 3);
      ld("lhu_17",  F_HU, 32'h17,  32'h00000088, 1'b0, 4);
      st("sw_3ff",  F_W,  32'h3FF, 32'h11223344, 1'b0, 4);
      ld("lw_3fc",  F_W,  32'h3FC, 32'h44000000, 1'b0, 3);
      ld("lw_0",    F_W,  32'h0,   32'h00112233, 1'b0, 3);
      ld("lw_3ff",  F_W,  32'h3FF, 32'h11223344, 1'b0, 4);
      st("sh_17",   F_H,  32'h17,  32'h0000BEEF, 1'b0, 4);
      ld("lw_14",   F_W,  32'h14,  32'hEF776655, 1'b0, 3);
      ld("lw_18",   F_W,  32'h18,  32'h000000BE, 1'b0, 3);
      w10 = 32'h44332211;
`else
      ld("lw_13",   F_W,  32'h13,  32'h0, 1'b1, 3);
      st("sw_13",   F_W,  32'h13,  32'h12345678, 1'b1, 3);
      ld("lw_10c",  F_W,  32'h10,  32'hDEADAAEF, 1'b0, 3);
      ld("lw_14",   F_W,  32'h14,  32'h0, 1'b0, 3);
      ld("lh_21",   F_H,  32'h21,  32'h0, 1'b1, 3);
      st("sh_23",   F_H,  32'h23,  32'h0000FFFF, 1'b1, 3);
      ld("lw_20c",  F_W,  32'h20,  32'h80010000, 1'b0, 3);
      st("sw_3ff",  F_W,  32'h3FF, 32'h11223344, 1'b1, 3);
      ld("lw_3fc",  F_W,  32'h3FC, 32'h0, 1'b0, 3);
      ld("lw_0",    F_W,  32'h0,   32'h0, 1'b0, 3);
      w10 = 32'hDEADAAEF;
`endif

      // Requests while busy are ignored: no extra completion, no write.
      ld("busy_lw", F_W, 32'h10, w10, 1'b0, 3);
      check("busy_ready", 32'(bus.oReady), 32'd0);
      bus.iReq    = 1'b1;
      bus.iWe     = 1'b1;
      bus.iFunct3 = F_W;
      bus.iAddr   = 32'h10;
      bus.iWrData = 32'h0;
      @(negedge iClk);
      bus.iReq = 1'b0;
      ld("post_busy_lw", F_W, 32'h10, w10, 1'b0, 3);
      drain();

      // Reset during ACC of a store: outputs return to reset values, no oDone.
      bus.iReq    = 1'b1;
      bus.iWe     = 1'b1;
      bus.iFunct3 = F_W;
      bus.iAddr   = 32'h40;
      bus.iWrData = 32'hCAFEF00D;
      @(negedge iClk);
      bus.iReq = 1'b0;
      iRst = 1'b1;
      #1;
      check("midrst_ready", 32'(bus.oReady), 32'd1);
      check("midrst_done",  32'(bus.oDone), 32'd0);
      check("midrst_rd",    bus.oRdData, 32'h0);
      check("midrst_mis",   32'(bus.oMisalign), 32'd0);
      @(negedge iClk);
      iRst = 1'b0;
      repeat (6) @(negedge iClk);
      ld("recover_lw", F_W, 32'h10, w10, 1'b0, 3);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
